// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial controller for a 4-bit pipelined ALU. It slices WIDTH-bit ADD/SUB/AND/XOR
// commands into nibble issues and reassembles the returned nibbles into one result.
module alu_nibble_sequencer #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic             res_ovf,
    output logic [3:0]       alu_x,
    output logic [3:0]       alu_y,
    output logic             alu_carry_in,
    output logic             alu_end_bar,
    output logic             alu_cmpl_x,
    output logic             alu_cmpl_y,
    output logic             alu_op_xor,
    output logic             alu_op_and,
    output logic             alu_op_arith,
    input  logic [3:0]       alu_z,
    input  logic             alu_carry_out
);

    localparam int NN = WIDTH / 4;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IW-1:0] LAST_NIB = IW'(NN - 1);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        LOGIC_ISSUE,
        DRAIN,
        ARITH_ISSUE,
        ARITH_WAIT,
        DONE
    } state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       carry_in;
        logic       end_bar;
        logic       cmpl_x;
        logic       cmpl_y;
        logic       op_xor;
        logic       op_and;
        logic       op_arith;
    } alu_drive_t;

    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic [IW-1:0]    nib_q;
    logic [IW-1:0]    nib_next;
    logic [IW-1:0]    issue_idx_q;
    alu_drive_t       drv_q;
    logic             issue_now;
    logic             b_eff_msb;

    logic [ALU_LAT-1:0] trk_vld;
    logic [IW-1:0]      trk_idx [ALU_LAT];
    logic               ret_vld;
    logic [IW-1:0]      ret_idx;

    function automatic alu_drive_t encode(op_t op, logic [3:0] x, logic [3:0] y,
                                          logic carry_in);
        alu_drive_t d;
        d   = '0;
        d.x = x;
        d.y = y;
        case (op)
            OP_ADD, OP_SUB: begin
                d.op_arith = 1'b1;
                d.end_bar  = 1'b1;
                d.cmpl_y   = (op == OP_SUB);
                d.carry_in = carry_in;
            end
            OP_AND:  d.op_and = 1'b1;
            default: d.op_xor = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic [3:0] nibble(logic [WIDTH-1:0] v, logic [IW-1:0] k);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NN; i++)
            if (k == IW'(i)) n = v[4*i +: 4];
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] place(logic [WIDTH-1:0] v, logic [IW-1:0] k,
                                               logic [3:0] z);
        logic [WIDTH-1:0] r;
        r = v;
        for (int i = 0; i < NN; i++)
            if (k == IW'(i)) r[4*i +: 4] = z;
        return r;
    endfunction

    assign nib_next  = nib_q + 1'b1;
    assign issue_now = drv_q.op_arith | drv_q.op_and | drv_q.op_xor;
    assign b_eff_msb = (op_q == OP_SUB) ? ~b_q[WIDTH-1] : b_q[WIDTH-1];
    assign ret_vld   = trk_vld[ALU_LAT-1];
    assign ret_idx   = trk_idx[ALU_LAT-1];

    assign alu_x        = drv_q.x;
    assign alu_y        = drv_q.y;
    assign alu_carry_in = drv_q.carry_in;
    assign alu_end_bar  = drv_q.end_bar;
    assign alu_cmpl_x   = drv_q.cmpl_x;
    assign alu_cmpl_y   = drv_q.cmpl_y;
    assign alu_op_xor   = drv_q.op_xor;
    assign alu_op_and   = drv_q.op_and;
    assign alu_op_arith = drv_q.op_arith;

    // The tracker is fed from the registered drive, so its output lines up with the ALU result.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_vld <= '0;
        end else begin
            trk_vld[0] <= issue_now;
            for (int i = 1; i < ALU_LAT; i++) trk_vld[i] <= trk_vld[i-1];
        end
        // NOTE: index entries carry no reset; they are only read when the matching valid bit is set.
        trk_idx[0] <= issue_idx_q;
        for (int i = 1; i < ALU_LAT; i++) trk_idx[i] <= trk_idx[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_cout    <= 1'b0;
            res_ovf     <= 1'b0;
            drv_q       <= '0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            nib_q       <= '0;
            issue_idx_q <= '0;
        end else begin
            // NOTE: the ALU drive falls back to all-zero every cycle; only issue branches override it.
            drv_q <= '0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= op_t'(cmd_op);
                        a_q       <= cmd_a;
                        b_q       <= cmd_b;
                        cin_q     <= cmd_cin;
                        res_data  <= '0;
                        res_cout  <= 1'b0;
                        res_ovf   <= 1'b0;
                        nib_q     <= '0;
                        cmd_ready <= 1'b0;
                        state     <= cmd_op[1] ? LOGIC_ISSUE : ARITH_ISSUE;
                    end
                end

                LOGIC_ISSUE: begin
                    drv_q       <= encode(op_q, nibble(a_q, nib_q), nibble(b_q, nib_q), 1'b0);
                    issue_idx_q <= nib_q;
                    if (nib_q == LAST_NIB) state <= DRAIN;
                    else                   nib_q <= nib_next;
                end

                DRAIN: begin
                    if (ret_vld) begin
                        res_data <= place(res_data, ret_idx, alu_z);
                        if (ret_idx == LAST_NIB) begin
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                ARITH_ISSUE: begin
                    drv_q       <= encode(op_q, nibble(a_q, nib_q), nibble(b_q, nib_q),
                                          (op_q == OP_SUB) ? 1'b1 : cin_q);
                    issue_idx_q <= nib_q;
                    state       <= ARITH_WAIT;
                end

                ARITH_WAIT: begin
                    if (ret_vld) begin
                        res_data <= place(res_data, ret_idx, alu_z);
                        if (ret_idx == LAST_NIB) begin
                            res_cout  <= alu_carry_out;
                            res_ovf   <= (a_q[WIDTH-1] == b_eff_msb) && (alu_z[3] != a_q[WIDTH-1]);
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            // Next nibble launches on the edge its carry returns: ALU_LAT+1 clocks per trip.
                            drv_q       <= encode(op_q, nibble(a_q, nib_next), nibble(b_q, nib_next),
                                                  alu_carry_out);
                            issue_idx_q <= nib_next;
                            nib_q       <= nib_next;
                        end
                    end
                end

                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: a behavioural 4-bit ALU with a fixed latency drives the
// sequencer; results are compared against whole-word arithmetic on the operands.
module tb_alu_nibble_sequencer;

    localparam int WIDTH   = 16;
    localparam int ALU_LAT = 8;
    localparam int NN      = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_cout;
    logic             res_ovf;
    logic [3:0]       alu_x;
    logic [3:0]       alu_y;
    logic             alu_carry_in;
    logic             alu_end_bar;
    logic             alu_cmpl_x;
    logic             alu_cmpl_y;
    logic             alu_op_xor;
    logic             alu_op_and;
    logic             alu_op_arith;
    logic [3:0]       alu_z;
    logic             alu_carry_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_ovf(res_ovf),
        .alu_x(alu_x), .alu_y(alu_y), .alu_carry_in(alu_carry_in),
        .alu_end_bar(alu_end_bar), .alu_cmpl_x(alu_cmpl_x), .alu_cmpl_y(alu_cmpl_y),
        .alu_op_xor(alu_op_xor), .alu_op_and(alu_op_and), .alu_op_arith(alu_op_arith),
        .alu_z(alu_z), .alu_carry_out(alu_carry_out)
    );

    // Stand-in ALU: result appears ALU_LAT clocks after its inputs; idle slots return junk.
    logic [3:0] xe, ye;
    logic [4:0] alu_now, junk;
    logic [4:0] alu_pipe [ALU_LAT];

    assign xe = alu_cmpl_x ? ~alu_x : alu_x;
    assign ye = alu_cmpl_y ? ~alu_y : alu_y;

    always_comb begin
        alu_now = junk;
        if (alu_op_arith)    alu_now = {1'b0, xe} + {1'b0, ye} + {4'b0, alu_carry_in};
        else if (alu_op_and) alu_now = {1'b0, xe & ye};
        else if (alu_op_xor) alu_now = {1'b0, xe ^ ye};
    end

    always @(posedge clk) begin
        junk        <= 5'($urandom);
        alu_pipe[0] <= alu_now;
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end

    assign alu_z         = alu_pipe[ALU_LAT-1][3:0];
    assign alu_carry_out = alu_pipe[ALU_LAT-1][4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] drive_now();
        return {alu_x, alu_y, alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y,
                alu_op_xor, alu_op_and, alu_op_arith};
    endfunction

    // Whole-word reference: result, carry, overflow and the carry into each nibble.
    function automatic void model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input logic cin,
                                  output logic [WIDTH-1:0] d, output logic co,
                                  output logic ov, output logic [NN-1:0] cins);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] bp;
        logic             c0;
        logic [31:0]      part;
        logic [31:0]      mask;
        bp   = (op == 2'b01) ? ~b : b;
        c0   = (op == 2'b01) ? 1'b1 : ((op == 2'b00) ? cin : 1'b0);
        cins = '0;
        co   = 1'b0;
        ov   = 1'b0;
        case (op)
            2'b10:   d = a & b;
            2'b11:   d = a ^ b;
            default: begin
                s  = {1'b0, a} + {1'b0, bp} + (WIDTH+1)'(c0);
                d  = s[WIDTH-1:0];
                co = s[WIDTH];
                ov = (a[WIDTH-1] == bp[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
                for (int k = 0; k < NN; k++) begin
                    mask    = (32'd1 << (4*k)) - 32'd1;
                    part    = (32'(a) & mask) + (32'(bp) & mask) + 32'(c0);
                    cins[k] = part[4*k];
                end
            end
        endcase
    endfunction

    task automatic send(input string name, input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin);
        logic [WIDTH-1:0] exp_d;
        logic             exp_co, exp_ov;
        logic [NN-1:0]    exp_ci;
        logic [14:0]      d, exp_drv;
        int               n, lat, idle_bad, exp_cyc;
        int               iss_cyc[$];
        logic [14:0]      iss_drv[$];

        model(op, a, b, cin, exp_d, exp_co, exp_ov, exp_ci);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        check({name, " accept"}, cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_a = WIDTH'($urandom); cmd_b = WIDTH'($urandom);
        cmd_op = 2'($urandom); cmd_cin = 1'($urandom);

        lat = 0; idle_bad = 0;
        while (lat < 200) begin
            d = drive_now();
            if (d[2:0] != 3'b000) begin
                iss_cyc.push_back(lat);
                iss_drv.push_back(d);
                if ($countones(d[2:0]) != 1) idle_bad++;
            end else if (d != 15'd0) begin
                idle_bad++;
            end
            if (res_valid) break;
            res_ready = 1'($urandom);
            tick();
            lat++;
        end
        res_ready = 1'b0;

        check({name, " latency"}, lat, op[1] ? NN + ALU_LAT + 1 : NN * (ALU_LAT + 1) + 1);
        check({name, " issue count"}, iss_cyc.size(), NN);
        check({name, " idle drive"}, idle_bad, 0);
        for (int k = 0; k < NN && k < iss_cyc.size(); k++) begin
            exp_cyc = op[1] ? 1 + k : 1 + k * (ALU_LAT + 1);
            exp_drv = {a[4*k +: 4], b[4*k +: 4], exp_ci[k], ~op[1], 1'b0, op == 2'b01,
                       op == 2'b11, op == 2'b10, ~op[1]};
            check($sformatf("%s issue%0d cycle", name, k), iss_cyc[k], exp_cyc);
            check($sformatf("%s issue%0d drive", name, k), iss_drv[k], exp_drv);
        end
        check({name, " data"}, res_data, exp_d);
        check({name, " cout"}, res_cout, exp_co);
        check({name, " ovf"}, res_ovf, exp_ov);
    endtask

    task automatic consume(input string name);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({name, " res_valid drop"}, res_valid, 0);
        check({name, " cmd_ready back"}, cmd_ready, 1);
    endtask

    initial begin
        logic [WIDTH-1:0] hold;
        int               bad;
        int               n;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cmd_cin = 1'b0; res_ready = 1'b0;
        repeat (3) tick();
        check("rst cmd_ready", cmd_ready, 0);
        check("rst res_valid", res_valid, 0);
        check("rst res_data", {res_data, res_cout, res_ovf}, 0);
        check("rst alu drive", drive_now(), 0);
        rst = 1'b0;
        tick();
        check("post-rst cmd_ready", cmd_ready, 1);

        send("add carry", 2'b00, 16'h00FF, 16'h0001, 1'b0);   consume("add carry");
        send("sub borrow", 2'b01, 16'h0000, 16'h0001, 1'b0);  consume("sub borrow");
        send("add ovf", 2'b00, 16'h7FFF, 16'h0001, 1'b0);     consume("add ovf");
        send("add wrap", 2'b00, 16'hFFFF, 16'h0001, 1'b0);    consume("add wrap");
        send("xor", 2'b11, 16'hA5A5, 16'h0FF0, 1'b1);         consume("xor");
        send("and", 2'b10, 16'hA5A5, 16'h0FF0, 1'b1);         consume("and");
        send("add cin", 2'b00, 16'h0FFF, 16'h0000, 1'b1);     consume("add cin");

        // Result held back while a new command waits at the door.
        send("bp add", 2'b00, 16'h1234, 16'h4321, 1'b1);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 16'h3C3C; cmd_b = 16'h0FF0; cmd_cin = 1'b0;
        hold = res_data;
        bad  = 0;
        repeat (20) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== hold || cmd_ready !== 1'b0) bad++;
        end
        check("bp hold stable", bad, 0);
        consume("bp release");
        send("bp and", 2'b10, 16'h3C3C, 16'h0FF0, 1'b0);     consume("bp and");

        // Abort an ADD mid-flight; its nibbles still emerge from the ALU afterwards.
        cmd_op = 2'b00; cmd_a = 16'h0F0F; cmd_b = 16'h0101; cmd_cin = 1'b1; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        check("abort accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        check("abort alu drive", drive_now(), 0);
        check("abort res_valid", res_valid, 0);
        check("abort cmd_ready", cmd_ready, 0);
        check("abort res_data", {res_data, res_cout, res_ovf}, 0);
        rst = 1'b0;
        send("xor after abort", 2'b11, 16'hFFFF, 16'h0000, 1'b0);
        consume("xor after abort");

        for (int i = 0; i < 16; i++) begin
            send($sformatf("rand%0d", i), 2'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                 1'($urandom));
            repeat ($urandom_range(0, 3)) tick();
            consume($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
